// File: rtl/dll_rx_packet_demux_q_if.sv
`default_nettype none
// ============================================================================
// Module      : dll_rx_packet_demux_q_if
// Description : RX word input, DLLP/TLP FIFO outputs and statistics bundle
//               for the DLL RX packet demux.
// Revision    : 1.0 - initial release
// ============================================================================
interface dll_rx_packet_demux_q_if #(
    parameter int DATA_W = 1196,
    parameter int DLLP_W = 48,
    parameter int CNT_W  = 16
);
    logic [1:0]        dlc_state_i;
    logic [DATA_W-1:0] rx_data_i;
    logic              rx_valid_i;
    logic              rx_ready_o;
    logic [DLLP_W-1:0] dllp_o;
    logic              dllp_valid_o;
    logic              dllp_ready_i;
    logic [DATA_W-1:0] tlp_o;
    logic              tlp_valid_o;
    logic              tlp_ready_i;
    logic [CNT_W-1:0]  dllp_cnt_o;
    logic [CNT_W-1:0]  tlp_cnt_o;
    logic [CNT_W-1:0]  drop_cnt_o;

    modport master (
        output dlc_state_i, rx_data_i, rx_valid_i, dllp_ready_i, tlp_ready_i,
        input  rx_ready_o, dllp_o, dllp_valid_o, tlp_o, tlp_valid_o,
        input  dllp_cnt_o, tlp_cnt_o, drop_cnt_o
    );

    modport slave (
        input  dlc_state_i, rx_data_i, rx_valid_i, dllp_ready_i, tlp_ready_i,
        output rx_ready_o, dllp_o, dllp_valid_o, tlp_o, tlp_valid_o,
        output dllp_cnt_o, tlp_cnt_o, drop_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/dll_rx_packet_demux_q.sv
`default_nettype none
// ============================================================================
// Module      : dll_rx_packet_demux_q
// Description : Splits accepted RX words into buffered DLLP and TLP FIFOs,
//               flushing both when the link leaves DL_ACTIVE. Statistics
//               counters are built only when DLL_RX_DEMUX_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module dll_rx_packet_demux_q_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         flush,
    input  wire logic         push,
    input  wire logic         pop,
    input  wire logic [W-1:0] din,
    output logic      [W-1:0] dout,
    output logic              valid,
    output logic              full
);
    localparam int              c_AW   = $clog2(DEPTH);
    localparam logic [c_AW:0]   c_FULL = (c_AW + 1)'(DEPTH);

    logic [W-1:0]    r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic            w_push;
    logic            w_pop;

    assign valid  = (r_count != '0);
    assign full   = (r_count == c_FULL);
    assign dout   = valid ? r_mem[r_rd_ptr] : '0;
    // flush outranks both push and pop in the same cycle
    assign w_push = push & ~full & ~flush;
    assign w_pop  = pop & valid & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    // storage needs no reset: dout is masked to zero while empty
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= din;
    end
endmodule

module dll_rx_packet_demux_q #(
    parameter int DATA_W     = 1196,
    parameter int DLLP_W     = 48,
    parameter int DLLP_DEPTH = 4,
    parameter int TLP_DEPTH  = 4,
    parameter int CNT_W      = 16
) (
    input  wire logic                clk,
    input  wire logic                rst_n,
    dll_rx_packet_demux_q_if.slave   bus
);
    logic w_active;
    logic w_is_dllp;
    logic w_xfer;
    logic w_flush;
    logic w_dllp_push;
    logic w_tlp_push;
    logic w_dllp_full;
    logic w_tlp_full;
    logic r_active_q;

    assign w_active    = (bus.dlc_state_i == 2'b11);
    assign w_is_dllp   = (bus.rx_data_i[DATA_W-1:DLLP_W] == '0);
    assign bus.rx_ready_o = ~w_active | (~w_dllp_full & ~w_tlp_full);
    assign w_xfer      = bus.rx_valid_i & bus.rx_ready_o;
    assign w_dllp_push = w_xfer & w_active & w_is_dllp;
    assign w_tlp_push  = w_xfer & w_active & ~w_is_dllp;
    assign w_flush     = r_active_q & ~w_active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_active_q <= 1'b0;
        else        r_active_q <= w_active;
    end

    dll_rx_packet_demux_q_fifo #(.W(DLLP_W), .DEPTH(DLLP_DEPTH)) u_dllp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (w_flush),
        .push  (w_dllp_push),
        .pop   (bus.dllp_ready_i),
        .din   (bus.rx_data_i[DLLP_W-1:0]),
        .dout  (bus.dllp_o),
        .valid (bus.dllp_valid_o),
        .full  (w_dllp_full)
    );

    dll_rx_packet_demux_q_fifo #(.W(DATA_W), .DEPTH(TLP_DEPTH)) u_tlp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (w_flush),
        .push  (w_tlp_push),
        .pop   (bus.tlp_ready_i),
        .din   (bus.rx_data_i),
        .dout  (bus.tlp_o),
        .valid (bus.tlp_valid_o),
        .full  (w_tlp_full)
    );

`ifdef DLL_RX_DEMUX_STATS_EN
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic             w_drop;
    logic [CNT_W-1:0] r_dllp_cnt;
    logic [CNT_W-1:0] r_tlp_cnt;
    logic [CNT_W-1:0] r_drop_cnt;

    assign w_drop = w_xfer & ~w_active;

    // saturating; flush leaves the statistics untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dllp_cnt <= '0;
            r_tlp_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_dllp_push && r_dllp_cnt != c_CNT_MAX) r_dllp_cnt <= r_dllp_cnt + 1'b1;
            if (w_tlp_push  && r_tlp_cnt  != c_CNT_MAX) r_tlp_cnt  <= r_tlp_cnt  + 1'b1;
            if (w_drop      && r_drop_cnt != c_CNT_MAX) r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign bus.dllp_cnt_o = r_dllp_cnt;
    assign bus.tlp_cnt_o  = r_tlp_cnt;
    assign bus.drop_cnt_o = r_drop_cnt;
`else
    assign bus.dllp_cnt_o = '0;
    assign bus.tlp_cnt_o  = '0;
    assign bus.drop_cnt_o = '0;
`endif
endmodule
`default_nettype wire
